// File: rtl/sum_block_acc.sv
// rtl/sum_block_acc.sv - accumulates LEN consecutive adder sums into one block total with overflow flag
// Optional SUM_BLOCK_ACC_SAT_EN: clamp the accumulator at its maximum instead of wrapping.
module sum_block_acc #(
    parameter int IN_W  = 33,
    parameter int LEN   = 16,
    parameter int ACC_W = 37,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic [ACC_W:0]     sum_full;
    logic               accept;
    logic               handshake;
    logic               close;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    // One extra bit on the adder exposes the carry-out used as the overflow indication.
    assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};

    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (accept) begin
            cnt_nxt = cnt + CNT_W'(1);
            ovf_nxt = ovf | sum_full[ACC_W];
`ifdef SUM_BLOCK_ACC_SAT_EN
            acc_nxt = (ovf | sum_full[ACC_W]) ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
            acc_nxt = sum_full[ACC_W-1:0];
`endif
        end
    end

    // A flush on an empty block with no sample arriving has nothing to close.
    assign close = (state == ACC) &&
                   ((accept && (cnt_nxt == CNT_W'(LEN))) ||
                    (flush && ((cnt != '0) || accept)));

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (close)     state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = ACC;
            default:                state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == ACC);
            if (close) begin
                out_acc   <= acc_nxt;
                out_cnt   <= cnt_nxt;
                out_ovf   <= ovf_nxt;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
                if (handshake) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
